rx_frame_packer: RTL and testbench

RX_FRAME_PACKER -- requirements
Module: rx_frame_packer

---
 rtl/rx_frame_packer.sv | 194 +++++++++++++++++++
 tb/tb_rx_frame_packer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_packer.sv
// -----------------------------------------------------------------------------
// rx_frame_packer
//
// Drains IQ pairs from an RX FIFO and emits them as a framed 16-bit host
// stream.  Every frame is:
//     SYNC_WORD, seq, I0, Q0, I1, Q1, ... I(FRAME_LEN-1), Q(FRAME_LEN-1)
// and out_last marks the final Q word.  Samples are sign-extended from
// IQ_PAIR_WIDTH/2 bits to 16 bits.
//
// States:
//     state  | meaning
//     IDLE   | waiting for enable, no FIFO activity
//     HDR    | presenting SYNC_WORD
//     SEQ    | presenting the frame sequence number
//     SAMP_I | presenting I half of the held pair (valid once it has landed)
//     SAMP_Q | presenting Q half of the held pair, last on the final pair
//
// Ports:
//     clk         single clock (also the RX FIFO read clock)
//     reset_n     asynchronous active-low reset
//     enable      level-sensitive streaming enable, sampled at frame boundaries
//     fifo_empty  RX FIFO empty flag
//     fifo_q      RX FIFO read data, valid the cycle after fifo_rd
//     fifo_rd     RX FIFO read request, one word per asserted cycle
//     out_data    host stream word
//     out_valid   out_data valid
//     out_ready   host accepts the word when out_valid & out_ready
//     out_last    final word of a frame
//     busy        high whenever the packer is not in IDLE
// -----------------------------------------------------------------------------
module rx_frame_packer #(
    parameter int          IQ_PAIR_WIDTH = 24,
    parameter int          FRAME_LEN     = 256,
    parameter logic [15:0] SYNC_WORD     = 16'hA55A
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     fifo_empty,
    input  logic [IQ_PAIR_WIDTH-1:0] fifo_q,
    output logic                     fifo_rd,
    output logic [15:0]              out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy
);

    localparam int          HALF      = IQ_PAIR_WIDTH / 2;
    localparam logic [15:0] LAST_PAIR = 16'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        SEQ    = 3'd2,
        SAMP_I = 3'd3,
        SAMP_Q = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [IQ_PAIR_WIDTH-1:0] pair_q;
    logic                     pair_vld;
    logic                     rd_pend;
    logic [15:0]              pair_cnt;
    logic [15:0]              seq_cnt;

    logic                     xfer;
    logic                     last_pair;
    logic [HALF-1:0]          half_i;
    logic [HALF-1:0]          half_q;

    function automatic logic [15:0] sext(input logic [HALF-1:0] h);
        logic [15:0] r;
        r           = {16{h[HALF-1]}};
        r[HALF-1:0] = h;
        return r;
    endfunction

    assign half_i    = pair_q[HALF-1:0];
    assign half_q    = pair_q[2*HALF-1:HALF];
    assign last_pair = (pair_cnt == LAST_PAIR);
    assign xfer      = out_valid & out_ready;
    assign busy      = (state != IDLE);

    // The pair is fetched as early as HDR so that the first I word is ready
    // the moment the header words have gone out.  Only one read may be in
    // flight, which also keeps fifo_rd from firing on consecutive cycles.
    assign fifo_rd = ((state == HDR) || (state == SEQ) || (state == SAMP_I))
                   && !pair_vld && !rd_pend && !fifo_empty;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = 16'h0000;
        out_last  = 1'b0;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = SYNC_WORD;
                if (out_ready) begin
                    state_nxt = SEQ;
                end
            end
            SEQ: begin
                out_valid = 1'b1;
                out_data  = seq_cnt;
                if (out_ready) begin
                    state_nxt = SAMP_I;
                end
            end
            SAMP_I: begin
                out_valid = pair_vld;
                out_data  = sext(half_i);
                if (pair_vld && out_ready) begin
                    state_nxt = SAMP_Q;
                end
            end
            SAMP_Q: begin
                out_valid = 1'b1;
                out_data  = sext(half_q);
                out_last  = last_pair;
                if (out_ready) begin
                    if (!last_pair) begin
                        state_nxt = SAMP_I;
                    end else if (enable) begin
                        state_nxt = HDR;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Holding register: lands the cycle after the read, released once the
    // Q half has been accepted.  A read is never in flight while the pair
    // is still held, so the two branches cannot collide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend  <= 1'b0;
            pair_vld <= 1'b0;
            pair_q   <= '0;
        end else begin
            rd_pend <= fifo_rd;
            if (rd_pend) begin
                pair_q   <= fifo_q;
                pair_vld <= 1'b1;
            end else if ((state == SAMP_Q) && xfer) begin
                pair_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pair_cnt <= 16'h0000;
        end else if ((state == SAMP_Q) && xfer) begin
            if (last_pair) begin
                pair_cnt <= 16'h0000;
            end else begin
                pair_cnt <= pair_cnt + 16'd1;
            end
        end
    end

    // Sequence number survives enable toggling; it wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_cnt <= 16'h0000;
        end else if ((state == SEQ) && xfer) begin
            seq_cnt <= seq_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_rx_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_packer
//
// Bench for rx_frame_packer (FRAME_LEN=2, 24-bit pairs).  A queue models the
// RX FIFO; a frame-level reference model builds the expected host stream
// from the words pushed into that FIFO.
// -----------------------------------------------------------------------------
module tb_rx_frame_packer;

    localparam int W  = 24;
    localparam int FL = 2;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          fifo_empty;
    logic [W-1:0]  fifo_q;
    logic          fifo_rd;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;

    rx_frame_packer #(
        .IQ_PAIR_WIDTH(W),
        .FRAME_LEN    (FL),
        .SYNC_WORD    (16'hA55A)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .fifo_q    (fifo_q),
        .fifo_rd   (fifo_rd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_rd;
    int           proto_err;

    logic [W-1:0] fq[$];
    logic [W-1:0] src[$];
    word_t        got[$];
    word_t        exp_q[$];

    logic         s_rd, s_valid, s_last, s_busy, s_ready;
    logic [15:0]  s_data;
    logic         p_valid, p_ready, p_last, p_rd, have_prev;
    logic [15:0]  p_data;
    bit           rand_ready;
    bit           stall_rand;

    word_t        basic_exp [8];

    // ---------------- environment ----------------
    task automatic step();
        @(negedge clk);
        s_rd    = fifo_rd;
        s_valid = out_valid;
        s_data  = out_data;
        s_last  = out_last;
        s_busy  = busy;
        s_ready = out_ready;
        if (have_prev && p_valid && !p_ready &&
            (!s_valid || s_data !== p_data || s_last !== p_last)) proto_err++;
        if (have_prev && s_rd && p_rd) proto_err++;
        if (s_rd && fifo_empty) proto_err++;
        @(posedge clk);
        #1;
        if (s_rd) begin
            n_rd++;
            if (fq.size() == 0) proto_err++;
            else fifo_q = fq.pop_front();
        end else begin
            fifo_q = W'($urandom);
        end
        if (s_valid && s_ready) got.push_back(word_t'({s_data, s_last}));
        p_valid   = s_valid;
        p_ready   = s_ready;
        p_data    = s_data;
        p_last    = s_last;
        p_rd      = s_rd;
        have_prev = 1'b1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        fifo_empty = (fq.size() == 0) || (stall_rand && ($urandom_range(0, 3) == 0));
    endtask

    task automatic run_until_got(input int n, input int budget);
        int c = 0;
        while (got.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic push_word(input logic [W-1:0] w);
        fq.push_back(w);
        src.push_back(w);
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_q     = '0;
        rand_ready = 1'b0;
        stall_rand = 1'b0;
        have_prev  = 1'b0;
        p_rd       = 1'b0;
        fq.delete();
        src.delete();
        got.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        n_rd      = 0;
        proto_err = 0;
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] sx(input int v);
        if (v >= 2048) return 16'(v - 4096);
        return 16'(v);
    endfunction

    // Frames built from the words in src, in order; sequence numbers count
    // up from seq0.
    task automatic model_frames(input int nframes, input int seq0);
        int idx = 0;
        int wi;
        exp_q.delete();
        for (int f = 0; f < nframes; f++) begin
            exp_q.push_back(word_t'({16'hA55A, 1'b0}));
            exp_q.push_back(word_t'({16'(seq0 + f), 1'b0}));
            for (int p = 0; p < FL; p++) begin
                wi = int'(src[idx]);
                idx++;
                exp_q.push_back(word_t'({sx(wi % 4096), 1'b0}));
                exp_q.push_back(word_t'({sx(wi / 4096), (p == FL - 1)}));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b1;
        out_ready  = 1'b1;
        fifo_empty = 1'b0;
        #12;
        n_checks++;
        if ({fifo_rd, out_valid, out_last, busy, out_data} !== 20'h0)
            $display("FAIL reset_outputs: got rd=%b vld=%b last=%b busy=%b data=%h, want all 0",
                     fifo_rd, out_valid, out_last, busy, out_data);
        else n_pass++;
        apply_reset();
        push_word(24'h123456);
        push_word(24'h654321);
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        repeat (4) step();
        n_checks++;
        if (n_rd !== 0) $display("FAIL idle_no_read: got %0d reads, want 0", n_rd);
        else n_pass++;
        n_checks++;
        if ({s_busy, s_valid, s_data} !== 18'h0)
            $display("FAIL idle_outputs: got busy=%b vld=%b data=%h, want 0", s_busy, s_valid, s_data);
        else n_pass++;
    endtask

    task automatic test_basic();
        apply_reset();
        push_word(24'h8007FF);
        push_word(24'h001FFF);
        push_word(W'($urandom));
        push_word(W'($urandom));
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b1;
        run_until_got(8, 100);
        n_checks++;
        if (got.size() !== 8) $display("FAIL basic_count: got %0d words, want 8", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < 8; i++) begin
            n_checks++;
            if (got[i] !== basic_exp[i])
                $display("FAIL basic_word%0d: got %h last=%b, want %h last=%b",
                         i, got[i].data, got[i].last, basic_exp[i].data, basic_exp[i].last);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        for (int i = 0; i < 10; i++) push_word(W'($urandom));
        rand_ready = 1'b1;
        stall_rand = 1'b1;
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b1;
        run_until_got(19, 2000);
        enable = 1'b0;
        run_until_got(24, 2000);
        repeat (20) step();
        model_frames(4, 0);
        n_checks++;
        if (got.size() !== 24) $display("FAIL bp_count: got %0d words, want 24", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i])
                $display("FAIL bp_word%0d: got %h last=%b, want %h last=%b",
                         i, got[i].data, got[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        n_checks++;
        if (n_rd !== 8) $display("FAIL bp_reads: got %0d fifo reads, want 8", n_rd);
        else n_pass++;
        n_checks++;
        if (proto_err !== 0) $display("FAIL bp_protocol: got %0d violations, want 0", proto_err);
        else n_pass++;
        n_checks++;
        if (s_busy !== 1'b0) $display("FAIL bp_idle: got busy=%b, want 0", s_busy);
        else n_pass++;
    endtask

    task automatic test_fifo_empty();
        int rd0;
        apply_reset();
        out_ready  = 1'b1;
        enable     = 1'b1;
        run_until_got(2, 50);
        n_checks++;
        if (got.size() !== 2) $display("FAIL empty_hdr_count: got %0d words, want 2", got.size());
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if ({s_valid, s_rd} !== 2'b00)
                $display("FAIL empty_stall%0d: got vld=%b rd=%b, want 0 0", i, s_valid, s_rd);
            else n_pass++;
        end
        rd0 = n_rd;
        push_word(24'h8007FF);
        push_word(24'h001FFF);
        fifo_empty = 1'b0;
        run_until_got(3, 50);
        n_checks++;
        if (n_rd - rd0 !== 1) $display("FAIL empty_resume_reads: got %0d reads, want 1", n_rd - rd0);
        else n_pass++;
        n_checks++;
        if (got.size() < 3 || got[2] !== word_t'({16'h07FF, 1'b0}))
            $display("FAIL empty_resume_word: got %0d words / %h, want 07FF",
                     got.size(), (got.size() >= 3) ? got[2].data : 16'h0);
        else n_pass++;
        n_checks++;
        if (proto_err !== 0) $display("FAIL empty_protocol: got %0d violations, want 0", proto_err);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        apply_reset();
        push_word(24'h8007FF);
        push_word(24'h001FFF);
        push_word(W'($urandom));
        push_word(W'($urandom));
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b1;
        run_until_got(3, 50);
        enable = 1'b0;
        run_until_got(6, 50);
        n_checks++;
        if (got.size() !== 6 || got[5] !== word_t'({16'h0001, 1'b1}))
            $display("FAIL drop_last: got %0d words / %h, want 6 words ending 0001 last",
                     got.size(), (got.size() > 0) ? got[got.size()-1].data : 16'h0);
        else n_pass++;
        step();
        n_checks++;
        if (s_busy !== 1'b0) $display("FAIL drop_busy: got busy=%b, want 0", s_busy);
        else n_pass++;
        repeat (10) step();
        n_checks++;
        if (n_rd !== 2 || got.size() !== 6)
            $display("FAIL drop_quiet: got %0d reads %0d words, want 2 reads 6 words", n_rd, got.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 4; i++) push_word(W'($urandom));
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b1;
        run_until_got(3, 50);
        out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if ({s_valid, s_busy} !== 2'b11)
            $display("FAIL mid_in_q: got vld=%b busy=%b, want 1 1", s_valid, s_busy);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({fifo_rd, out_valid, out_last, busy, out_data} !== 20'h0)
            $display("FAIL mid_async_reset: got rd=%b vld=%b last=%b busy=%b data=%h, want all 0",
                     fifo_rd, out_valid, out_last, busy, out_data);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        have_prev = 1'b0;
        fq.delete();
        src.delete();
        got.delete();
        push_word(W'($urandom));
        push_word(W'($urandom));
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b0;
        step();
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_until_got(6, 100);
        model_frames(1, 0);
        n_checks++;
        if (got.size() !== 6) $display("FAIL mid_count: got %0d words, want 6", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i])
                $display("FAIL mid_word%0d: got %h last=%b, want %h last=%b",
                         i, got[i].data, got[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
    endtask

    task automatic test_seq_persist();
        apply_reset();
        for (int i = 0; i < 4; i++) push_word(W'($urandom));
        fifo_empty = 1'b0;
        out_ready  = 1'b1;
        enable     = 1'b1;
        step();
        enable = 1'b0;
        run_until_got(6, 100);
        repeat (5) step();
        n_checks++;
        if (s_busy !== 1'b0) $display("FAIL seq_gap_idle: got busy=%b, want 0", s_busy);
        else n_pass++;
        enable = 1'b1;
        step();
        enable = 1'b0;
        run_until_got(12, 100);
        model_frames(2, 0);
        n_checks++;
        if (got.size() !== 12) $display("FAIL seq_count: got %0d words, want 12", got.size());
        else n_pass++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got[i] !== exp_q[i])
                $display("FAIL seq_word%0d: got %h last=%b, want %h last=%b",
                         i, got[i].data, got[i].last, exp_q[i].data, exp_q[i].last);
            else n_pass++;
        end
        n_checks++;
        if (proto_err !== 0) $display("FAIL seq_protocol: got %0d violations, want 0", proto_err);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        basic_exp[0] = word_t'({16'hA55A, 1'b0});
        basic_exp[1] = word_t'({16'h0000, 1'b0});
        basic_exp[2] = word_t'({16'h07FF, 1'b0});
        basic_exp[3] = word_t'({16'hF800, 1'b0});
        basic_exp[4] = word_t'({16'hFFFF, 1'b0});
        basic_exp[5] = word_t'({16'h0001, 1'b1});
        basic_exp[6] = word_t'({16'hA55A, 1'b0});
        basic_exp[7] = word_t'({16'h0001, 1'b0});
        n_rd       = 0;
        proto_err  = 0;
        have_prev  = 1'b0;
        p_rd       = 1'b0;
        rand_ready = 1'b0;
        stall_rand = 1'b0;
        fifo_q     = '0;

        test_reset();
        test_basic();
        test_backpressure();
        test_fifo_empty();
        test_enable_drop();
        test_reset_mid();
        test_seq_persist();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
